rng_fifo_bridge: RTL and testbench
==================================

RNG_FIFO_BRIDGE -- requirements
Module: rng_fifo_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_2000, base of the 3-register iomem window (word aligned).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of two, 2..16).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port iomem_valid, input, 1 bit: bus request valid.
REQ-006 SHALL have port iomem_ready, output, 1 bit: bus acknowledge, registered.
REQ-007 SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; 0 means read.
REQ-008 SHALL have port iomem_addr, input, 32 bits: bus address.
REQ-009 SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-010 SHALL have port iomem_rdata, output, 32 bits: read data, registered.
REQ-011 SHALL have port rng_re, output, 1 bit: read request to the upstream RNG.
REQ-012 SHALL have port rng_do, input, 32 bits: RNG output word.
REQ-013 SHALL have port rng_wait, input, 1 bit: RNG not ready; rng_do is invalid while high.

Function
REQ-014 SHALL decode three registers: DATA at BASE_ADDR+0, STATUS at +4, CTRL at +8; any other address SHALL get no response (iomem_ready stays 0).
REQ-015 SHALL ack a decoded access by driving iomem_ready=1 for exactly one cycle, on the cycle after iomem_valid=1 && iomem_ready=0 is sampled; no back-to-back ack for the same held request.
REQ-016 DATA read SHALL return the FIFO head word and pop it in the ack cycle; if the FIFO is empty it SHALL return 32'hFFFF_FFFF, pop nothing, and set sticky underflow.
REQ-017 DATA write SHALL be acked and ignored.
REQ-018 STATUS read SHALL return {16'h0, count[7:0], 4'h0, underflow, full, empty, enable} (bits 15:8 count, bit3 underflow, bit2 full, bit1 empty, bit0 enable); STATUS writes SHALL be acked and ignored.
REQ-019 CTRL write with wstrb[0]=1 SHALL set enable=wdata[0], flush when wdata[1]=1, and clear underflow when wdata[2]=1; CTRL read SHALL return {31'h0, enable}.
REQ-020 The fill FSM SHALL have states IDLE and REQ; IDLE->REQ when enable=1 and count<DEPTH; rng_re SHALL be 1 exactly while in REQ.
REQ-021 In REQ, on a cycle with rng_wait=0, rng_do SHALL be pushed to the FIFO tail and the FSM SHALL return to IDLE, giving at most one word per 2 cycles.
REQ-022 Clearing enable while in REQ SHALL NOT abort; the pending word completes, then the FSM stays in IDLE.
REQ-023 Flush SHALL empty the FIFO (count=0, pointers reset), force the FSM to IDLE and discard any word arriving that cycle; the FSM may re-enter REQ on the next cycle.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; a pop from a one-entry FIFO with a simultaneous push SHALL return the old head.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; a push SHALL never occur when count=DEPTH.
REQ-026 A flush and a DATA pop in the same cycle SHALL return the pre-flush head, and the FIFO SHALL end empty.

Reset
REQ-027 While rst_i=1: iomem_ready=0, iomem_rdata=0, rng_re=0, FSM=IDLE, count=0, pointers=0, enable=0, underflow=0; FIFO storage need not be cleared.
REQ-028 Reset asserted mid-REQ or mid-access SHALL abandon the transaction; no ack or push SHALL follow the reset cycle.

Verification
REQ-029 Reset, enable=0, read DATA -> rdata=32'hFFFF_FFFF, STATUS=32'h0000_000A (underflow, empty).
REQ-030 Write CTRL=1, RNG supplies 1..8 with rng_wait=0 -> rng_re pulses 8 times, STATUS count=8, full=1, rng_re stays 0; 8 DATA reads return 1..8 in order.
REQ-031 Enable, rng_wait held high 5 cycles then low with rng_do=32'hDEAD_BEEF -> rng_re high 6 cycles, single push, next DATA read=32'hDEAD_BEEF.
REQ-032 FIFO at count=3, DATA read coincides with a push -> count remains 3, returned word is the oldest entry.
REQ-033 FIFO full, write CTRL=32'h3 -> count=0, empty=1, refill restarts; write CTRL=32'h4 after an underflow -> STATUS bit3=0.
REQ-034 Access to BASE_ADDR+12 -> iomem_ready stays 0 for 10 cycles; rst_i pulsed during REQ -> rng_re=0 and count=0 the next cycle.

Source files
------------

// File: rtl/rng_fifo_bridge.sv
// Bridges an upstream RNG into a word FIFO that a CPU drains via a three-register
// iomem window (DATA, STATUS, CTRL). A two-state fill FSM requests one word at a time.
module rng_fifo_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_2000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        rng_re,
    input  logic [31:0] rng_do,
    input  logic        rng_wait
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [0:0]    state;
    logic          enable;
    logic          underflow;

    logic        sel_data;
    logic        sel_status;
    logic        sel_ctrl;
    logic        is_write;
    logic        accept;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        flush;
    logic [31:0] read_word;
    logic        unused_wdata;

    assign sel_data   = (iomem_addr == BASE_ADDR);
    assign sel_status = (iomem_addr == BASE_ADDR + 32'd4);
    assign sel_ctrl   = (iomem_addr == BASE_ADDR + 32'd8);
    assign is_write   = |iomem_wstrb;

    // A held request is accepted only while no ack is outstanding, so each access acks once.
    assign accept = iomem_valid && !iomem_ready && (sel_data || sel_status || sel_ctrl);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = accept && sel_data && !is_write && !empty;
    assign flush = accept && sel_ctrl && iomem_wstrb[0] && iomem_wdata[1];
    assign push  = (state == ST_REQ) && !rng_wait && !flush && !full;

    assign rng_re       = (state == ST_REQ) && !rst_i;
    assign unused_wdata = ^iomem_wdata[31:3];

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        read_word = 32'h0;
        if (sel_data) begin
            read_word = empty ? 32'hFFFF_FFFF : mem[rd_ptr];
        end else if (sel_status) begin
            read_word = {16'h0, 8'(count), 4'h0, underflow, full, empty, enable};
        end else if (sel_ctrl) begin
            read_word = {31'h0, enable};
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define valid entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= rng_do;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            enable      <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            iomem_ready <= accept;
            if (accept) begin
                iomem_rdata <= is_write ? 32'h0 : read_word;
            end
            if (accept && sel_data && !is_write && empty) begin
                underflow <= 1'b1;
            end
            if (accept && sel_ctrl && iomem_wstrb[0]) begin
                enable <= iomem_wdata[0];
                if (iomem_wdata[2]) begin
                    underflow <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush wins over any word arriving this cycle; a same-cycle pop already read the head.
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            case (state)
                ST_IDLE: if (enable && !full) state <= ST_REQ;
                ST_REQ:  if (!rng_wait) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_fifo_bridge.sv
// Scoreboard bench for rng_fifo_bridge: a queue-based reference model predicts every
// bus response and the RNG request line; a negedge monitor compares against the DUT.
module tb_rng_fifo_bridge;

    localparam logic [31:0] BASE        = 32'h0300_2000;
    localparam logic [31:0] ADDR_DATA   = BASE;
    localparam logic [31:0] ADDR_STATUS = BASE + 32'd4;
    localparam logic [31:0] ADDR_CTRL   = BASE + 32'd8;
    localparam int          DEPTH       = 8;

    logic        clk;
    logic        rst_i;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        rng_re;
    logic [31:0] rng_do;
    logic        rng_wait;

    rng_fifo_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .rng_re     (rng_re),
        .rng_do     (rng_do),
        .rng_wait   (rng_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RNG source ----------------
    // mode 0: always ready, sequential words; mode 1: directed; mode 2: random
    int          rng_mode = 1;
    logic        h_wait   = 1'b1;
    logic [31:0] h_do     = 32'h0;
    logic        r_wait   = 1'b0;
    logic [31:0] r_do     = 32'h0;
    int          push_cnt = 0;
    int          seq_base = 0;

    assign rng_wait = (rng_mode == 1) ? h_wait : (rng_mode == 2) ? r_wait : 1'b0;
    assign rng_do   = (rng_mode == 1) ? h_do : (rng_mode == 2) ? r_do
                                      : 32'(push_cnt - seq_base + 1);

    always @(negedge clk) begin
        r_wait = ($urandom_range(0, 3) == 0);
        r_do   = $urandom;
    end

    always @(posedge clk) begin
        if (!rst_i && rng_re === 1'b1 && !rng_wait) push_cnt <= push_cnt + 1;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    bit          m_en, m_uf, m_req, m_ready, started;
    bit          m_acc, m_rd, m_flush, m_push, m_next;
    logic [31:0] m_e;

    always @(posedge clk) begin
        if (rst_i) begin
            m_req   = 1'b0;
            m_ready = 1'b0;
            m_en    = 1'b0;
            m_uf    = 1'b0;
            mq.delete();
        end else begin
            m_acc   = iomem_valid && !m_ready &&
                      (iomem_addr == ADDR_DATA || iomem_addr == ADDR_STATUS || iomem_addr == ADDR_CTRL);
            m_rd    = (iomem_wstrb == 4'h0);
            m_flush = m_acc && iomem_addr == ADDR_CTRL && iomem_wstrb[0] && iomem_wdata[1];
            m_push  = m_req && !rng_wait && !m_flush;
            if (m_flush) m_next = 1'b0;
            else if (m_req) m_next = rng_wait;
            else m_next = m_en && (mq.size() < DEPTH);

            if (m_acc) begin
                if (!m_rd) begin
                    exp_q.push_back('{chk: 1'b0, data: 32'h0});
                end else begin
                    if (iomem_addr == ADDR_DATA) m_e = (mq.size() == 0) ? 32'hFFFF_FFFF : mq[0];
                    else if (iomem_addr == ADDR_STATUS)
                        m_e = {16'h0, 8'(mq.size()), 4'h0, m_uf, mq.size() == DEPTH, mq.size() == 0, m_en};
                    else m_e = {31'h0, m_en};
                    exp_q.push_back('{chk: 1'b1, data: m_e});
                    if (iomem_addr == ADDR_DATA) begin
                        if (mq.size() == 0) m_uf = 1'b1;
                        else void'(mq.pop_front());
                    end
                end
                if (!m_rd && iomem_addr == ADDR_CTRL && iomem_wstrb[0]) begin
                    m_en = iomem_wdata[0];
                    if (iomem_wdata[2]) m_uf = 1'b0;
                end
            end
            if (m_flush) mq.delete();
            else if (m_push) mq.push_back(rng_do);
            m_req   = m_next;
            m_ready = m_acc;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (started) begin
            check("rng_re", {31'h0, rng_re}, {31'h0, m_req && !rst_i});
            if (iomem_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.chk) check("rdata", iomem_rdata, mon_e.data);
                end
            end
        end
    end

    // ---------------- bus driver ----------------
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (iomem_ready !== 1'b1 && n < 20);
        if (iomem_ready !== 1'b1) check("ack_timeout", {31'h0, iomem_ready}, 32'h1);
        r = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus(a, 4'h0, 32'h0, r);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, 4'hF, d, dummy);
    endtask

    task automatic one_push(input logic [31:0] v);
        h_do   = v;
        h_wait = 1'b0;
        @(negedge clk);
        h_wait = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required the run to finish earlier");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] r;
    int          cnt;
    logic [3:0]  ws;
    logic [31:0] wd;

    initial begin
        rst_i       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'h0, iomem_ready}, 32'h0);
        check("reset_rdata", iomem_rdata, 32'h0);
        check("reset_rng_re", {31'h0, rng_re}, 32'h0);
        started = 1'b1;
        rst_i   = 1'b0;

        // empty read underflows; CTRL bit2 clears it
        rd(ADDR_DATA, r);   check("empty_data", r, 32'hFFFF_FFFF);
        rd(ADDR_STATUS, r); check("status_uf_empty", r, 32'h0000_000A);
        wr(ADDR_CTRL, 32'h4);
        rd(ADDR_STATUS, r); check("status_uf_clear", r, 32'h0000_0002);

        // fill with 1..8 from an always-ready RNG, then drain in order
        rng_mode = 0;
        seq_base = push_cnt;
        wr(ADDR_CTRL, 32'h1);
        repeat (30) @(negedge clk);
        rd(ADDR_STATUS, r); check("status_full", r, 32'h0000_0805);
        for (int i = 0; i < DEPTH; i++) begin
            rd(ADDR_DATA, r);
            check("fill_order", r, 32'(i + 1));
        end

        // stalled RNG: six request cycles, one push
        wr(ADDR_CTRL, 32'h2);
        h_wait   = 1'b1;
        h_do     = 32'hDEAD_BEEF;
        rng_mode = 1;
        wr(ADDR_CTRL, 32'h1);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cnt += int'(rng_re);
            if (i == 5) h_wait = 1'b0;
            if (i == 6) h_wait = 1'b1;
        end
        check("wait_re_cycles", 32'(cnt), 32'd6);
        wr(ADDR_CTRL, 32'h0);
        rd(ADDR_DATA, r); check("wait_word", r, 32'hDEAD_BEEF);
        h_wait = 1'b0;
        repeat (2) @(negedge clk);
        rd(ADDR_STATUS, r); check("pending_completes", r, 32'h0000_0100);

        // pop coinciding with push at count 3
        wr(ADDR_CTRL, 32'h2);
        h_wait = 1'b1;
        wr(ADDR_CTRL, 32'h1);
        @(negedge clk);
        one_push(32'h11);
        one_push(32'h22);
        one_push(32'h33);
        iomem_valid = 1'b1;
        iomem_addr  = ADDR_DATA;
        iomem_wstrb = 4'h0;
        h_do        = 32'h44;
        h_wait      = 1'b0;
        @(negedge clk);
        h_wait = 1'b1;
        check("simul_ack", {31'h0, iomem_ready}, 32'h1);
        check("simul_head", iomem_rdata, 32'h11);
        iomem_valid = 1'b0;
        rd(ADDR_STATUS, r); check("simul_count", r, 32'h0000_0301);

        // flush while full, refill, then underflow clear
        wr(ADDR_CTRL, 32'h2);
        rng_mode = 0;
        wr(ADDR_CTRL, 32'h1);
        repeat (30) @(negedge clk);
        rd(ADDR_STATUS, r); check("full_before_flush", r, 32'h0000_0805);
        wr(ADDR_CTRL, 32'h3);
        rd(ADDR_STATUS, r); check("after_flush", r, 32'h0000_0003);
        repeat (30) @(negedge clk);
        rd(ADDR_STATUS, r); check("refilled", r, 32'h0000_0805);
        wr(ADDR_CTRL, 32'h2);
        rd(ADDR_DATA, r);   check("empty_data2", r, 32'hFFFF_FFFF);
        rd(ADDR_STATUS, r); check("status_uf2", r, 32'h0000_000A);
        wr(ADDR_CTRL, 32'h4);
        rd(ADDR_STATUS, r); check("uf_cleared", r, 32'h0000_0002);

        // undecoded address never acks
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'd12;
        iomem_wstrb = 4'h0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(iomem_ready);
        end
        check("undecoded_acks", 32'(cnt), 32'd0);
        iomem_valid = 1'b0;

        // reset in the middle of a request
        h_wait   = 1'b1;
        rng_mode = 1;
        wr(ADDR_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        check("re_before_rst", {31'h0, rng_re}, 32'h1);
        @(posedge clk); #2 rst_i = 1'b1;
        @(posedge clk); #2 rst_i = 1'b0;
        @(negedge clk);
        check("re_after_rst", {31'h0, rng_re}, 32'h0);
        h_wait = 1'b0;
        rd(ADDR_STATUS, r); check("status_after_rst", r, 32'h0000_0002);

        // randomized traffic against the model
        rng_mode = 2;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd = {$urandom, 3'b000} | {29'h0, ($urandom_range(0, 9) == 0),
                                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7)};
            case ($urandom_range(0, 2))
                0:       bus(ADDR_DATA, ws, wd, r);
                1:       bus(ADDR_STATUS, ws, wd, r);
                default: bus(ADDR_CTRL, ws, wd, r);
            endcase
        end
        wr(ADDR_CTRL, 32'h2);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
